// File: rtl/hsv_core_mem_response_queue.sv
// In-order response tracker for hsv_core mem: matches AXI R/B to issued requests, extends load data.
// Optional feature macro: HSV_MEM_WRITE_ERR_EN adds the sticky write_error output.
module hsv_core_mem_response_queue #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_POSTED = 8,
    parameter int TAG_W      = 64,
    localparam int SHIFT_W   = $clog2(XLEN / 8)
) (
    input  logic               clk_core,
    input  logic               rst_core_n,
    input  logic               flush,
    input  logic               commit_stall,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_is_read,
    input  logic               in_is_io,
    input  logic [1:0]         in_size,
    input  logic               in_sign_extend,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_unaligned,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               dmem_r_valid,
    output logic               dmem_r_ready,
    input  logic [XLEN-1:0]    dmem_r_data,
    input  logic [1:0]         dmem_r_resp,
    input  logic               dmem_b_valid,
    output logic               dmem_b_ready,
    input  logic [1:0]         dmem_b_resp,
    input  logic               commit_mem,
    output logic               out_valid,
    output logic               out_exception,
    output logic               out_writeback,
    output logic [XLEN-1:0]    out_result,
    output logic [TAG_W-1:0]   out_tag
`ifdef HSV_MEM_WRITE_ERR_EN
    ,
    output logic               write_error
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int POST_W = $clog2(MAX_POSTED + 2 * DEPTH + 1) + 1;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    typedef struct packed {
        logic               is_read;
        logic               is_io;
        logic [1:0]         size;
        logic               sign_extend;
        logic [SHIFT_W-1:0] shift;
        logic               unaligned;
        logic [TAG_W-1:0]   tag;
    } entry_t;

    entry_t             entry_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [CNT_W-1:0]   drain_reg, drain_next;
    logic [POST_W-1:0]  posted_reg, posted_next;

    logic               out_valid_reg, out_exception_reg, out_writeback_reg;
    logic [XLEN-1:0]    out_result_reg;
    logic [TAG_W-1:0]   out_tag_reg;

    entry_t             head;
    logic               head_valid, head_load, head_mem_store, head_io_store, head_done;
    logic               drain_busy, posted_busy;
    logic               enq, deq, r_fire, b_fire;
    logic               drop_r, head_r_fire, posted_b_fire, head_b_fire;
    logic [DEPTH-1:0]   slot_load, slot_store;
    logic [CNT_W-1:0]   flush_loads, flush_stores;
    logic [XLEN-1:0]    shifted, word_ext, load_value;
    logic               unused_inputs;

    assign head           = entry_mem[rd_ptr_reg];
    assign head_valid     = count_reg != '0;
    assign head_load      = head_valid & head.is_read & ~head.unaligned;
    assign head_mem_store = head_valid & ~head.is_read & ~head.is_io & ~head.unaligned;
    assign head_io_store  = head_valid & ~head.is_read & head.is_io & ~head.unaligned;
    assign drain_busy     = drain_reg != '0;
    assign posted_busy    = posted_reg != '0;

    assign in_ready     = (count_reg != CNT_W'(DEPTH)) & ~drain_busy;
    assign dmem_r_ready = drain_busy | (head_load & ~commit_stall);
    assign dmem_b_ready = posted_busy | (head_io_store & ~commit_stall);

    // Beats go to the drain/posted counters first; only with those at zero do they belong to the head.
    assign r_fire        = dmem_r_valid & dmem_r_ready;
    assign b_fire        = dmem_b_valid & dmem_b_ready;
    assign drop_r        = r_fire & drain_busy;
    assign head_r_fire   = r_fire & ~drain_busy;
    assign posted_b_fire = b_fire & posted_busy;
    assign head_b_fire   = b_fire & ~posted_busy;

    always_comb begin
        head_done = 1'b0;
        if (head_valid) begin
            if (head.unaligned)
                head_done = 1'b1;
            else if (head.is_read)
                head_done = dmem_r_valid & ~drain_busy;
            else if (head.is_io)
                head_done = dmem_b_valid & ~posted_busy;
            else
                head_done = posted_reg < POST_W'(MAX_POSTED);
        end
    end

    assign enq = in_valid & in_ready & ~flush;
    assign deq = head_done & ~commit_stall & ~flush;

    // Per-slot classification of live entries that already issued a bus transaction.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        localparam logic [PTR_W-1:0] SLOT = PTR_W'(gi);
        logic [PTR_W-1:0] offset;
        logic             live;
        assign offset         = SLOT - rd_ptr_reg;
        assign live           = {1'b0, offset} < count_reg;
        assign slot_load[gi]  = live & entry_mem[gi].is_read & ~entry_mem[gi].unaligned;
        assign slot_store[gi] = live & ~entry_mem[gi].is_read & ~entry_mem[gi].unaligned;
    end

    always_comb begin
        flush_loads  = '0;
        flush_stores = '0;
        for (int i = 0; i < DEPTH; i++) begin
            flush_loads  = flush_loads + CNT_W'(slot_load[i]);
            flush_stores = flush_stores + CNT_W'(slot_store[i]);
        end
    end

    always_comb begin
        drain_next  = drain_reg - CNT_W'(drop_r);
        posted_next = posted_reg - POST_W'(posted_b_fire);
        count_next  = count_reg + CNT_W'(enq) - CNT_W'(deq);
        if (flush) begin
            // Responses still owed to flushed entries must be absorbed later.
            drain_next  = drain_next + flush_loads - CNT_W'(head_r_fire);
            posted_next = posted_next + POST_W'(flush_stores) - POST_W'(head_b_fire);
            count_next  = '0;
        end else if (deq && head_mem_store) begin
            posted_next = posted_next + POST_W'(1);
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drain_reg  <= '0;
            posted_reg <= '0;
        end else begin
            count_reg  <= count_next;
            drain_reg  <= drain_next;
            posted_reg <= posted_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (enq)
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (deq)
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (enq)
            entry_mem[wr_ptr_reg] <= {in_is_read, in_is_io, in_size, in_sign_extend,
                                      in_shift, in_unaligned, in_tag};
    end

    assign shifted = dmem_r_data >> {head.shift, 3'b000};

    if (XLEN > 32) begin : g_word_ext
        assign word_ext = {{(XLEN-32){head.sign_extend & shifted[31]}}, shifted[31:0]};
    end else begin : g_word_pass
        assign word_ext = shifted;
    end

    always_comb begin
        load_value = shifted;
        case (head.size)
            SIZE_BYTE:  load_value = {{(XLEN-8){head.sign_extend & shifted[7]}}, shifted[7:0]};
            SIZE_HALF:  load_value = {{(XLEN-16){head.sign_extend & shifted[15]}}, shifted[15:0]};
            SIZE_WORD:  load_value = word_ext;
            SIZE_DWORD: load_value = shifted;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            out_valid_reg     <= 1'b0;
            out_exception_reg <= 1'b0;
            out_writeback_reg <= 1'b0;
            out_result_reg    <= '0;
            out_tag_reg       <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (!commit_stall) begin
            out_valid_reg <= deq;
            if (deq) begin
                out_exception_reg <= head.unaligned | (head_load & dmem_r_resp[1])
                                   | (head_io_store & dmem_b_resp[1]);
                out_writeback_reg <= head.is_read;
                out_result_reg    <= head_load ? load_value : '0;
                out_tag_reg       <= head.tag;
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_exception = out_exception_reg;
    assign out_writeback = out_writeback_reg;
    assign out_result    = out_result_reg;
    assign out_tag       = out_tag_reg;

`ifdef HSV_MEM_WRITE_ERR_EN
    // Posted-store errors cannot be tied to an instruction any more, so they only raise a flag.
    logic write_error_reg;
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n)
            write_error_reg <= 1'b0;
        else if (posted_b_fire && dmem_b_resp[1])
            write_error_reg <= 1'b1;
    end
    assign write_error = write_error_reg;
`endif

    assign unused_inputs = ^{commit_mem, dmem_r_resp[0], dmem_b_resp[0]};

    if (XLEN == 32) begin : g_no_dword
        assert property (@(posedge clk_core) disable iff (!rst_core_n)
                         (in_valid && in_ready) |-> (in_size != SIZE_DWORD));
    end

endmodule
